// File: rtl/stopwatch_core_if.sv
// Control pulses into the stopwatch and the display/status it reports back.
// The master side drives the pulses; the core is the slave.
interface stopwatch_core_if;
  logic        start_stop;
  logic        lap;
  logic        clear;
  logic [15:0] disp;
  logic        running;
  logic        paused;
  logic        lap_active;
  logic        tick;
  logic        overflow;

  modport master (
    output start_stop, lap, clear,
    input  disp, running, paused, lap_active, tick, overflow
  );

  modport slave (
    input  start_stop, lap, clear,
    output disp, running, paused, lap_active, tick, overflow
  );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with run/pause/lap control and a TICK_DIV-cycle prescaler.
// WRAP selects rollover at 99:59 or saturation into PAUSE.
module stopwatch_core #(
  parameter int TICK_DIV = 100000,
  parameter bit WRAP     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_core_if.slave  bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [15:0] disp_reg, disp_next;
  logic        running_reg, paused_reg, lap_active_reg;
  logic        tick_reg, tick_next;
  logic        overflow_reg, overflow_next;
  logic [15:0] count_inc;
  logic        count_rolls;
  logic        counting;

  // One-second BCD increment with the 9/5/9/9 digit limits.
  always_comb begin
    count_inc   = count_reg;
    count_rolls = 1'b0;
    if (count_reg[3:0] != 4'd9) begin
      count_inc[3:0] = count_reg[3:0] + 4'd1;
    end else begin
      count_inc[3:0] = 4'd0;
      if (count_reg[7:4] != 4'd5) begin
        count_inc[7:4] = count_reg[7:4] + 4'd1;
      end else begin
        count_inc[7:4] = 4'd0;
        if (count_reg[11:8] != 4'd9) begin
          count_inc[11:8] = count_reg[11:8] + 4'd1;
        end else begin
          count_inc[11:8] = 4'd0;
          if (count_reg[15:12] != 4'd9) begin
            count_inc[15:12] = count_reg[15:12] + 4'd1;
          end else begin
            count_inc[15:12] = 4'd0;
            count_rolls      = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    presc_next    = presc_reg;
    disp_next     = disp_reg;
    tick_next     = 1'b0;
    overflow_next = 1'b0;

    // A saturated count stops the prescaler so no further tick can occur.
    counting = ((state_reg == RUN) || (state_reg == LAP)) &&
               !((WRAP == 1'b0) && (count_reg == 16'h9959));

    if (counting) begin
      if (presc_reg == PRESC_TOP) begin
        presc_next = '0;
        count_next = count_inc;
        tick_next  = 1'b1;
        if (WRAP == 1'b1) overflow_next = count_rolls;
        else              overflow_next = (count_inc == 16'h9959);
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (bus.start_stop) state_next = RUN;
      end
      RUN: begin
        if (bus.start_stop) state_next = PAUSE;
        else if (bus.lap)   state_next = LAP;
      end
      LAP: begin
        if (bus.start_stop) state_next = PAUSE;
        else if (bus.lap)   state_next = RUN;
      end
      PAUSE: begin
        if (bus.clear) begin
          state_next = IDLE;
          count_next = '0;
          presc_next = '0;
        end else if (bus.start_stop) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase

    if ((WRAP == 1'b0) && overflow_next) state_next = PAUSE;

    // Entering LAP captures the count; staying in LAP keeps it frozen.
    if (!((state_reg == LAP) && (state_next == LAP))) disp_next = count_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      presc_reg      <= '0;
      disp_reg       <= '0;
      running_reg    <= 1'b0;
      paused_reg     <= 1'b0;
      lap_active_reg <= 1'b0;
      tick_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      presc_reg      <= presc_next;
      disp_reg       <= disp_next;
      running_reg    <= (state_next == RUN) || (state_next == LAP);
      paused_reg     <= (state_next == PAUSE);
      lap_active_reg <= (state_next == LAP);
      tick_reg       <= tick_next;
      overflow_reg   <= overflow_next;
    end
  end

  assign bus.disp       = disp_reg;
  assign bus.running    = running_reg;
  assign bus.paused     = paused_reg;
  assign bus.lap_active = lap_active_reg;
  assign bus.tick       = tick_reg;
  assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core at TICK_DIV=4: vector table, directed corner sequences,
// and random pulses against a seconds-based reference model.
module tb_stopwatch_core;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic rst_w;
  logic rst_s;
  always #5 clk = ~clk;

  stopwatch_core_if sw_w();
  stopwatch_core_if sw_s();

  stopwatch_core #(.TICK_DIV(TDIV), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(rst_w), .bus(sw_w)
  );
  stopwatch_core #(.TICK_DIV(TDIV), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(rst_s), .bus(sw_s)
  );

  // {disp, running, paused, lap_active, tick, overflow}
  logic [20:0] obs_w, obs_s;
  assign obs_w = {sw_w.disp, sw_w.running, sw_w.paused, sw_w.lap_active, sw_w.tick, sw_w.overflow};
  assign obs_s = {sw_s.disp, sw_s.running, sw_s.paused, sw_s.lap_active, sw_s.tick, sw_s.overflow};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cycle_w(input bit ss, input bit lp, input bit cl);
    sw_w.start_stop = ss;
    sw_w.lap        = lp;
    sw_w.clear      = cl;
    @(posedge clk);
    #1;
    sw_w.start_stop = 1'b0;
    sw_w.lap        = 1'b0;
    sw_w.clear      = 1'b0;
  endtask

  task automatic cycle_s(input bit ss, input bit lp, input bit cl);
    sw_s.start_stop = ss;
    sw_s.lap        = lp;
    sw_s.clear      = cl;
    @(posedge clk);
    #1;
    sw_s.start_stop = 1'b0;
    sw_s.lap        = 1'b0;
    sw_s.clear      = 1'b0;
  endtask

  // ---------------- reference model: elapsed seconds + cycle phase ----------------
  int m_secs, m_phase, m_frozen;
  bit m_run, m_paused, m_lap, m_tick, m_ovf;

  function automatic logic [15:0] to_bcd(input int s);
    int mn, sc;
    mn = s / 60;
    sc = s % 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic void model_reset();
    m_secs = 0; m_phase = 0; m_frozen = 0;
    m_run = 0; m_paused = 0; m_lap = 0; m_tick = 0; m_ovf = 0;
  endfunction

  function automatic void model_step(input bit ss, input bit lp, input bit cl);
    m_tick = 0;
    m_ovf  = 0;
    if (m_run) begin
      m_phase++;
      if (m_phase == TDIV) begin
        m_phase = 0;
        m_secs++;
        m_tick = 1;
        if (m_secs == 6000) begin
          m_secs = 0;
          m_ovf  = 1;
        end
      end
    end
    if (m_paused) begin
      if (cl) begin
        m_paused = 0; m_secs = 0; m_phase = 0;
      end else if (ss) begin
        m_paused = 0; m_run = 1;
      end
    end else if (m_run) begin
      if (ss) begin
        m_run = 0; m_lap = 0; m_paused = 1;
      end else if (lp) begin
        m_lap = !m_lap;
        if (m_lap) m_frozen = m_secs;
      end
    end else if (ss) begin
      m_run = 1;
    end
  endfunction

  function automatic logic [20:0] model_obs();
    logic [15:0] d;
    d = m_lap ? to_bcd(m_frozen) : to_bcd(m_secs);
    return {d, m_run, m_paused, m_lap, m_tick, m_ovf};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit ss, lp, cl;
    logic [15:0] disp;
    bit run, pau, lapa, tck, ovf;
  } vec_t;
  localparam int NVEC = 30;
  vec_t vecs[NVEC];

  function automatic void set_vec(input int i, input bit ss, input bit lp, input bit cl,
                                  input logic [15:0] d, input bit r, input bit p,
                                  input bit l, input bit t);
    vecs[i].ss = ss; vecs[i].lp = lp; vecs[i].cl = cl;
    vecs[i].disp = d; vecs[i].run = r; vecs[i].pau = p;
    vecs[i].lapa = l; vecs[i].tck = t; vecs[i].ovf = 1'b0;
  endfunction

  task automatic wait_tick_w(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      cycle_w(0, 0, 0);
      if (sw_w.tick) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    bit ss, lp, cl;
    int ticks, cyc, extra;
    logic [15:0] d;

    rst_w = 1'b1; rst_s = 1'b1;
    sw_w.start_stop = 0; sw_w.lap = 0; sw_w.clear = 0;
    sw_s.start_stop = 0; sw_s.lap = 0; sw_s.clear = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(obs_w), 32'd0);
    rst_w = 1'b0;

    //          idx ss lp cl disp     run pau lap tick
    set_vec(0,  1, 0, 0, 16'h0000, 1, 0, 0, 0);
    set_vec(1,  0, 0, 0, 16'h0000, 1, 0, 0, 0);
    set_vec(2,  0, 0, 0, 16'h0000, 1, 0, 0, 0);
    set_vec(3,  0, 0, 0, 16'h0000, 1, 0, 0, 0);
    set_vec(4,  0, 0, 0, 16'h0001, 1, 0, 0, 1);
    set_vec(5,  0, 0, 0, 16'h0001, 1, 0, 0, 0);
    set_vec(6,  1, 0, 0, 16'h0001, 0, 1, 0, 0);
    for (int i = 7; i <= 16; i++) set_vec(i, 0, 0, 0, 16'h0001, 0, 1, 0, 0);
    set_vec(17, 1, 0, 0, 16'h0001, 1, 0, 0, 0);
    set_vec(18, 0, 0, 0, 16'h0001, 1, 0, 0, 0);
    set_vec(19, 0, 0, 0, 16'h0002, 1, 0, 0, 1);
    set_vec(20, 0, 1, 0, 16'h0002, 1, 0, 1, 0);
    set_vec(21, 0, 0, 0, 16'h0002, 1, 0, 1, 0);
    set_vec(22, 0, 0, 0, 16'h0002, 1, 0, 1, 0);
    set_vec(23, 0, 0, 0, 16'h0002, 1, 0, 1, 1);
    set_vec(24, 0, 1, 0, 16'h0003, 1, 0, 0, 0);
    set_vec(25, 0, 0, 1, 16'h0003, 1, 0, 0, 0);
    set_vec(26, 1, 1, 0, 16'h0003, 0, 1, 0, 0);
    set_vec(27, 1, 0, 1, 16'h0000, 0, 0, 0, 0);
    set_vec(28, 0, 1, 1, 16'h0000, 0, 0, 0, 0);
    set_vec(29, 1, 0, 0, 16'h0000, 1, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      cycle_w(vecs[i].ss, vecs[i].lp, vecs[i].cl);
      $display("vec %0d: ss=%0b lp=%0b cl=%0b -> obs %h", i, vecs[i].ss, vecs[i].lp, vecs[i].cl, obs_w);
      chk($sformatf("vec%0d", i), 32'(obs_w),
          32'({vecs[i].disp, vecs[i].run, vecs[i].pau, vecs[i].lapa, vecs[i].tck, vecs[i].ovf}));
    end

    // Lap freeze: latch 0005, hold for three ticks, release shows 0008.
    rst_w = 1'b1; @(posedge clk); #1; rst_w = 1'b0;
    cycle_w(1, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      cycle_w(0, 0, 0);
      if (sw_w.tick && sw_w.disp == 16'h0005) seen = 1'b1;
    end
    chk("lap_reach_0005", 32'(seen), 32'd1);
    cycle_w(0, 1, 0);
    chk("lap_enter", 32'({sw_w.disp, sw_w.lap_active, sw_w.running}), 32'({16'h0005, 1'b1, 1'b1}));
    for (int k = 0; k < 3; k++) begin
      wait_tick_w(10, seen);
      chk($sformatf("lap_hold_tick%0d", k), 32'({seen, sw_w.disp, sw_w.lap_active}),
          32'({1'b1, 16'h0005, 1'b1}));
    end
    cycle_w(0, 1, 0);
    $display("lap release: disp %h lap_active %0b", sw_w.disp, sw_w.lap_active);
    chk("lap_release", 32'({sw_w.disp, sw_w.lap_active}), 32'({16'h0008, 1'b0}));

    // Asynchronous reset in LAP at 0042, then a clean restart from IDLE.
    rst_w = 1'b1; @(posedge clk); #1; rst_w = 1'b0;
    cycle_w(1, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      cycle_w(0, 0, 0);
      if (sw_w.tick && sw_w.disp == 16'h0042) seen = 1'b1;
    end
    chk("async_reach_0042", 32'(seen), 32'd1);
    cycle_w(0, 1, 0);
    cycle_w(0, 0, 0);
    chk("async_in_lap", 32'({sw_w.disp, sw_w.lap_active}), 32'({16'h0042, 1'b1}));
    rst_w = 1'b1;
    #1;
    chk("async_reset_immediate", 32'(obs_w), 32'd0);
    @(posedge clk); #1;
    rst_w = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle_w(0, 0, 0);
      chk($sformatf("post_reset_idle%0d", k), 32'(obs_w), 32'd0);
    end
    cycle_w(1, 0, 0);
    for (int k = 1; k <= TDIV; k++) begin
      cycle_w(0, 0, 0);
      if (k == TDIV) chk("restart_first_tick", 32'({sw_w.tick, sw_w.disp}), 32'({1'b1, 16'h0001}));
      else           chk($sformatf("restart_no_tick%0d", k), 32'(sw_w.tick), 32'd0);
    end

    // Random pulses against the reference model.
    rst_w = 1'b1; @(posedge clk); #1; rst_w = 1'b0;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      ss = ($urandom_range(0, 15) == 0);
      lp = ($urandom_range(0, 11) == 0);
      cl = ($urandom_range(0, 7) == 0);
      cycle_w(ss, lp, cl);
      model_step(ss, lp, cl);
      chk($sformatf("random%0d", i), 32'(obs_w), 32'(model_obs()));
    end
    $display("random: %0d cycles, model at %0d s", 1500, m_secs);

    // Long runs to 99:59 on both variants in parallel.
    rst_w = 1'b1; @(posedge clk); #1; rst_w = 1'b0; rst_s = 1'b0;
    fork
      begin : wrap_run
        int t;
        bit s2;
        cycle_w(1, 0, 0);
        t = 0;
        for (int k = 0; k < 25000 && t < 5999; k++) begin
          cycle_w(0, 0, 0);
          if (sw_w.tick) t++;
        end
        chk("wrap_ticks_to_9959", 32'(t), 32'd5999);
        chk("wrap_at_9959", 32'({sw_w.disp, sw_w.overflow}), 32'({16'h9959, 1'b0}));
        wait_tick_w(10, s2);
        $display("wrap: disp %h overflow %0b running %0b", sw_w.disp, sw_w.overflow, sw_w.running);
        chk("wrap_rollover", 32'({s2, sw_w.disp, sw_w.overflow, sw_w.running}),
            32'({1'b1, 16'h0000, 1'b1, 1'b1}));
        cycle_w(0, 0, 0);
        chk("wrap_ovf_one_cycle", 32'({sw_w.overflow, sw_w.running}), 32'({1'b0, 1'b1}));
      end
      begin : sat_run
        int t;
        cycle_s(1, 0, 0);
        t = 0;
        for (int k = 0; k < 25000 && t < 5999; k++) begin
          cycle_s(0, 0, 0);
          if (sw_s.tick) t++;
        end
        chk("sat_ticks_to_9959", 32'(t), 32'd5999);
        $display("sat: disp %h overflow %0b paused %0b", sw_s.disp, sw_s.overflow, sw_s.paused);
        chk("sat_stop", 32'(obs_s), 32'({16'h9959, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}));
        t = 0;
        for (int k = 0; k < 20; k++) begin
          cycle_s(0, 0, 0);
          if (sw_s.tick || sw_s.overflow) t++;
        end
        chk("sat_no_more_ticks", 32'(t), 32'd0);
        chk("sat_hold", 32'({sw_s.disp, sw_s.paused}), 32'({16'h9959, 1'b1}));
        cycle_s(0, 0, 1);
        chk("sat_clear", 32'(obs_s), 32'd0);
      end
    join

    cyc = 0; extra = 0; ticks = 0; d = '0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
